mms_mem_arb: RTL and testbench

Memory-port arbiter and burst sequencer for the memory subsystem. It shares one 32-bit word-wide memory port among NREQ cache-side requesters: I-cache refill, D-cache refill and D-cache writeback. Each requester moves a whole 16-byte cache line, four 32-bit words, through one line-wide handshake. The block grants requesters round-robin, runs a 4-beat word burst on the memory port, and assembles or splits the line.

---
 rtl/mms_mem_arb.sv | 127 ++++++++++++
 tb/tb_mms_mem_arb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mms_mem_arb.sv
// Memory-port arbiter: round-robin grant of whole-line requests from NREQ
// cache-side requesters, sequenced as LINE_WORDS word beats on one memory port.
module mms_mem_arb #(
    parameter int NREQ       = 3,
    parameter int LINE_WORDS = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [NREQ-1:0]                        req_valid,
    output logic [NREQ-1:0]                        req_ready,
    input  logic [NREQ-1:0]                        req_we,
    input  logic [NREQ-1:0][31:0]                  req_addr,
    input  logic [NREQ-1:0][32*LINE_WORDS-1:0]     req_wdata,
    output logic [NREQ-1:0]                        rsp_valid,
    output logic [32*LINE_WORDS-1:0]               rsp_data,
    output logic                                   mem_req_valid,
    input  logic                                   mem_req_ready,
    output logic [31:0]                            mem_addr,
    output logic                                   mem_we,
    output logic [31:0]                            mem_wdata,
    input  logic                                   mem_rsp_valid,
    input  logic [31:0]                            mem_rsp_data
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(LINE_WORDS);
    localparam int CW = WW + 1;
    localparam int AW = 32 - WW - 2;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                       state, state_nxt;
    logic [IW-1:0]                rr_ptr, rr_nxt, gnt_idx, cur;
    logic                         gnt_found, grant;
    logic [AW-1:0]                addr_hi;
    logic                         we_q;
    logic [LINE_WORDS-1:0][31:0]  line_buf;
    logic [CW-1:0]                beat_cnt, rsp_cnt;
    logic                         beat_fire, rsp_fire, xfer_last;
    int                           idx;
    logic                         addr_lo_unused;

    // Round-robin search starting at rr_ptr, wrapping mod NREQ.
    always_comb begin
        gnt_idx   = '0;
        gnt_found = 1'b0;
        idx       = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!gnt_found && req_valid[IW'(idx)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(idx);
            end
        end
    end

    always_comb begin
        addr_lo_unused = 1'b0;
        for (int i = 0; i < NREQ; i++) addr_lo_unused = addr_lo_unused ^ (^req_addr[i][3:0]);
    end

    assign grant     = (state == IDLE) && gnt_found;
    assign rr_nxt    = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    assign beat_fire = mem_req_valid && mem_req_ready;
    assign rsp_fire  = (state == XFER) && !we_q && mem_rsp_valid && (rsp_cnt < CW'(LINE_WORDS));

    // Exit on the edge that completes the last beat/return so DONE lands at
    // T5 (write) / T6 (read) with zero-wait memory.
    assign xfer_last = we_q ? (beat_fire && beat_cnt == CW'(LINE_WORDS - 1))
                            : (rsp_fire  && rsp_cnt  == CW'(LINE_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_found) state_nxt = XFER;
            XFER:    if (xfer_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // req_ready is gated by rst_n so every output reads 0 while held in reset.
    always_comb begin
        req_ready     = '0;
        rsp_valid     = '0;
        mem_req_valid = 1'b0;
        if (grant && rst_n)  req_ready[gnt_idx] = 1'b1;
        if (state == DONE)   rsp_valid[cur]     = 1'b1;
        if (state == XFER && beat_cnt < CW'(LINE_WORDS)) mem_req_valid = 1'b1;
    end

    assign mem_addr  = {addr_hi, beat_cnt[WW-1:0], 2'b00};
    assign mem_we    = we_q;
    assign mem_wdata = line_buf[beat_cnt[WW-1:0]];
    assign rsp_data  = line_buf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            cur      <= '0;
            addr_hi  <= '0;
            we_q     <= 1'b0;
            line_buf <= '0;
            beat_cnt <= '0;
            rsp_cnt  <= '0;
        end else if (grant) begin
            rr_ptr   <= rr_nxt;
            cur      <= gnt_idx;
            addr_hi  <= req_addr[gnt_idx][31:32-AW];
            we_q     <= req_we[gnt_idx];
            line_buf <= req_wdata[gnt_idx];
            beat_cnt <= '0;
            rsp_cnt  <= '0;
        end else begin
            if (beat_fire) beat_cnt <= beat_cnt + 1'b1;
            if (rsp_fire) begin
                line_buf[rsp_cnt[WW-1:0]] <= mem_rsp_data;
                rsp_cnt                   <= rsp_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mms_mem_arb.sv
// Scoreboard bench for mms_mem_arb: zero-wait memory model with optional
// beat stall and spurious return injection.
module tb_mms_mem_arb;
    localparam int NREQ = 3;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [NREQ-1:0]           req_valid, req_ready, req_we, rsp_valid;
    logic [NREQ-1:0][31:0]     req_addr;
    logic [NREQ-1:0][127:0]    req_wdata;
    logic [127:0]              rsp_data;
    logic                      mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
    logic [31:0]               mem_addr, mem_wdata, mem_rsp_data;

    always #5 clk = ~clk;

    mms_mem_arb #(.NREQ(NREQ), .LINE_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
    );

    typedef struct { int port; logic [127:0] data; int lat; } rsp_t;
    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } beat_t;

    rsp_t        rsp_q[$];
    beat_t       beat_q[$];
    int          n_chk = 0, n_fail = 0;
    int          cyc = 0, acc_cyc = 0, stall_left = 0;
    logic [31:0] stall_addr = '0, acc_addr = '0;
    logic        acc_rd = 1'b0, spur = 1'b0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a[31:4] == 28'h8000123) return 32'h11 * (32'(a[3:2]) + 32'd1);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic push_exp(input int p, input logic we, input logic [31:0] a,
                            input logic [127:0] wd, input int lat);
        rsp_t r;
        beat_t b;
        logic [1:0] kk;
        for (int k = 0; k < 4; k++) begin
            kk      = 2'(k);
            b.addr  = {a[31:4], kk, 2'b00};
            b.we    = we;
            b.wdata = wd[32*k +: 32];
            beat_q.push_back(b);
            r.data[32*k +: 32] = we ? wd[32*k +: 32] : mem_word(b.addr);
        end
        r.port = p;
        r.lat  = lat;
        rsp_q.push_back(r);
    endtask

    task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [127:0] wd);
        int n = 0;
        bit got = 1'b0;
        req_addr[p]  = a;
        req_we[p]    = we;
        req_wdata[p] = wd;
        req_valid[p] = 1'b1;
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (req_ready[p]) got = 1'b1;
        end
        if (!got) chk("grant_timeout", 0, 1);
        @(posedge clk);
        #1 req_valid[p] = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((rsp_q.size() != 0 || beat_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", rsp_q.size() + beat_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_mem_req_valid"}, mem_req_valid, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
        chk({tag, "_rsp_data"}, rsp_data, 0);
    endtask

    // Memory return path: a beat accepted in cycle T returns during T+1.
    always @(posedge clk) begin
        cyc++;
        #1;
        mem_rsp_valid = acc_rd | spur;
        mem_rsp_data  = acc_rd ? mem_word(acc_addr) : 32'hDEAD_BEEF;
    end

    // Monitors and ready control, sampled mid-cycle.
    always @(negedge clk) begin
        beat_t b;
        rsp_t  r;
        if (stall_left > 0 && mem_req_valid && mem_addr[3:2] == 2'd2) begin
            chk("stall_addr", mem_addr, stall_addr);
            chk("stall_we", mem_we, 0);
            stall_left--;
            mem_req_ready = 1'b0;
        end else begin
            mem_req_ready = 1'b1;
        end
        acc_rd   = rst_n && mem_req_valid && mem_req_ready && !mem_we;
        acc_addr = mem_addr;
        if (rst_n && mem_req_valid && mem_req_ready) begin
            if (beat_q.size() == 0) chk("beat_unexpected", mem_addr, 0);
            else begin
                b = beat_q.pop_front();
                chk("beat_addr", mem_addr, b.addr);
                chk("beat_we", mem_we, b.we);
                if (b.we) chk("beat_wdata", mem_wdata, b.wdata);
            end
        end
        if (|(req_valid & req_ready)) acc_cyc = cyc;
        if (|rsp_valid) begin
            if (rsp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
            else begin
                r = rsp_q.pop_front();
                chk("rsp_port", rsp_valid, NREQ'(1) << r.port);
                chk("rsp_data", rsp_data, r.data);
                if (r.lat >= 0) chk("rsp_latency", cyc - acc_cyc, r.lat);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] wd1, wd2, wd3;
        wd1 = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
        wd2 = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
        wd3 = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;

        // Reset state, including a request held during reset.
        req_valid = 3'b001;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        req_valid = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single read, requester 1.
        push_exp(1, 1'b0, 32'h8000_1234, '0, 6);
        issue(1, 1'b0, 32'h8000_1234, '0);
        drain(100);

        // Writeback, requester 2.
        push_exp(2, 1'b1, 32'h0000_0100, wd1, 5);
        issue(2, 1'b1, 32'h0000_0100, wd1);
        drain(100);

        // All three at once, then 0 and 1 re-asserted while 2 is served.
        push_exp(0, 1'b0, 32'h0000_1000, '0, 6);
        push_exp(1, 1'b0, 32'h0000_2000, '0, 6);
        push_exp(2, 1'b1, 32'h0000_3000, wd2, 5);
        push_exp(0, 1'b0, 32'h0000_4000, '0, 6);
        push_exp(1, 1'b0, 32'h0000_5000, '0, 6);
        fork
            issue(0, 1'b0, 32'h0000_1000, '0);
            issue(1, 1'b0, 32'h0000_2000, '0);
            issue(2, 1'b1, 32'h0000_3000, wd2);
        join
        fork
            issue(0, 1'b0, 32'h0000_4000, '0);
            issue(1, 1'b0, 32'h0000_5000, '0);
        join
        drain(200);

        // Three-cycle stall on beat 2 of a read.
        stall_addr = 32'h0000_6008;
        stall_left = 3;
        push_exp(0, 1'b0, 32'h0000_6000, '0, 9);
        issue(0, 1'b0, 32'h0000_6000, '0);
        drain(100);
        chk("stall_consumed", stall_left, 0);

        // Spurious returns while idle and during a write burst.
        @(negedge clk) spur = 1'b1;
        repeat (3) @(negedge clk);
        spur = 1'b0;
        @(posedge clk);
        #1;
        push_exp(1, 1'b1, 32'h0000_7000, wd3, 5);
        issue(1, 1'b1, 32'h0000_7000, wd3);
        @(negedge clk) spur = 1'b1;
        repeat (2) @(negedge clk);
        spur = 1'b0;
        drain(100);
        push_exp(2, 1'b0, 32'h0000_8000, '0, 6);
        issue(2, 1'b0, 32'h0000_8000, '0);
        drain(100);

        // Reset after beat 1 of a read on port 1.
        push_exp(1, 1'b0, 32'h0000_9000, '0, 6);
        issue(1, 1'b0, 32'h0000_9000, '0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("midrst");
        beat_q.delete();
        rsp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp(0, 1'b0, 32'h0000_A000, '0, 6);
        push_exp(2, 1'b0, 32'h0000_B000, '0, 6);
        fork
            issue(0, 1'b0, 32'h0000_A000, '0);
            issue(2, 1'b0, 32'h0000_B000, '0);
        join
        drain(100);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
